spi_line_sender: RTL and testbench

//  Host-side transmitter for the LCD pixel link. Streams frames of LINES_PER_FRAME lines,

---
 rtl/spi_line_sender.sv | 184 ++++++++++++++++++
 tb/tb_spi_line_sender.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_line_sender.sv
// LCD pixel-link transmitter: frames of lines of 32-bit words sent LSB first on sck/mosi with vSync/hSync framing.
// Optional feature: define PATTERN_GEN_EN to replace i_data/i_valid with an internal {line, 8'h00, word} pattern.
module spi_line_sender #(
   parameter int unsigned CLOCK_SPEED     = 50,
   parameter int unsigned SCK_DIV         = 4,
   parameter int unsigned WORDS_PER_LINE  = 40,
   parameter int unsigned LINES_PER_FRAME = 1280,
   parameter int unsigned LINE_GAP        = 8
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [31:0] i_data,
   input  logic        i_valid,
   output logic        o_ready,
   output logic        o_sck,
   output logic        o_mosi,
   output logic        o_hSync,
   output logic        o_vSync,
   output logic        o_busy,
   output logic        o_frameDone,
   output logic        o_stall
);

   localparam int unsigned DIV_W      = $clog2(SCK_DIV) + 1;
   localparam int unsigned WORD_W     = $clog2(WORDS_PER_LINE + 1);
   localparam int unsigned LINE_W     = $clog2(LINES_PER_FRAME + 1);
   localparam int unsigned GAP_CYCLES = LINE_GAP * SCK_DIV;
   localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);

   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0]  DIV_HIGH  = DIV_W'(SCK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * SCK_DIV - 1);
   localparam logic [WORD_W-1:0] WORD_ONE  = WORD_W'(1);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_LINE - 1);
   localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);
   localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(LINES_PER_FRAME);
   localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   if (SCK_DIV < 1 || LINE_GAP < 1 || WORDS_PER_LINE < 1 ||
       LINES_PER_FRAME < 1 || CLOCK_SPEED < 1) begin : g_bad_param
      $error("spi_line_sender: all parameters must be >= 1");
   end

   typedef enum logic [2:0] {
      IDLE, VSYNC, LOAD, SHIFT, HSYNC, GAP, DONE
   } state_t;

   state_t              state, state_nxt;
   logic [DIV_W-1:0]    div_cnt;
   logic [4:0]          bit_cnt;
   logic [WORD_W-1:0]   word_cnt;
   logic [LINE_W-1:0]   line_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic [31:0]         shreg;
   logic [31:0]         word_in;
   logic                word_avail;
   logic                src_ready;
   logic                div_last, bit_last, word_last, gap_last, frame_last;

`ifdef PATTERN_GEN_EN
   assign word_in    = {16'(line_cnt), 8'h00, 8'(word_cnt)};
   assign word_avail = 1'b1;
   assign src_ready  = 1'b0;
`else
   assign word_in    = i_data;
   assign word_avail = i_valid;
   assign src_ready  = 1'b1;
`endif

   assign div_last   = (div_cnt == DIV_LAST);
   assign bit_last   = (bit_cnt == 5'd31);
   assign word_last  = (word_cnt == WORD_LAST);
   assign gap_last   = (gap_cnt == GAP_LAST);
   assign frame_last = (line_cnt == LINE_END);

   // sck is high during the second half of each bit period, so the rising edge
   // lands mid-bit and mosi only moves at the high->low transition.
   assign o_sck  = (state == SHIFT) && (div_cnt >= DIV_HIGH);
   assign o_mosi = shreg[0];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      o_busy      = 1'b1;
      o_vSync     = 1'b0;
      o_hSync     = 1'b0;
      o_ready     = 1'b0;
      o_stall     = 1'b0;
      o_frameDone = 1'b0;
      case (state)
         IDLE: begin
            o_busy = 1'b0;
            if (i_start) state_nxt = VSYNC;
         end
         VSYNC: begin
            o_vSync = 1'b1;
            if (div_last) state_nxt = LOAD;
         end
         LOAD: begin
            o_ready = src_ready;
            o_stall = !word_avail;
            if (word_avail) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (div_last && bit_last) state_nxt = word_last ? HSYNC : LOAD;
         end
         HSYNC: begin
            o_hSync = 1'b1;
            if (div_last) state_nxt = GAP;
         end
         GAP: begin
            if (gap_last) state_nxt = frame_last ? DONE : LOAD;
         end
         DONE: begin
            o_busy      = 1'b0;
            o_frameDone = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         line_cnt <= '0;
         gap_cnt  <= '0;
         shreg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               div_cnt  <= '0;
               bit_cnt  <= '0;
               word_cnt <= '0;
               line_cnt <= '0;
               gap_cnt  <= '0;
            end
            VSYNC: begin
               div_cnt <= div_last ? '0 : div_cnt + DIV_ONE;
            end
            LOAD: begin
               div_cnt <= '0;
               bit_cnt <= '0;
               if (word_avail) shreg <= word_in;
            end
            SHIFT: begin
               if (div_last) begin
                  div_cnt <= '0;
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_last ? '0 : bit_cnt + 5'd1;
                  if (bit_last) word_cnt <= word_cnt + WORD_ONE;
               end else begin
                  div_cnt <= div_cnt + DIV_ONE;
               end
            end
            HSYNC: begin
               if (div_last) begin
                  div_cnt  <= '0;
                  word_cnt <= '0;
                  line_cnt <= line_cnt + LINE_ONE;
               end else begin
                  div_cnt <= div_cnt + DIV_ONE;
               end
            end
            GAP: begin
               gap_cnt <= gap_last ? '0 : gap_cnt + GAP_ONE;
            end
            DONE: begin
               line_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_line_sender.sv
// Self-checking bench for spi_line_sender: step table for frame start, then randomized frames
// checked by a link receiver model against a word scoreboard (or the pattern formula).
module tb_spi_line_sender;

   localparam int unsigned SCK_DIV  = 4;
   localparam int unsigned WPL      = 8;
   localparam int unsigned LPF      = 4;
   localparam int unsigned LINE_GAP = 8;
   localparam int unsigned PAUSE    = 64 * SCK_DIV + 50;
`ifdef PATTERN_GEN_EN
   localparam int unsigned STALL_WANT = 0;
   localparam logic [6:0]  LOAD_OUT   = 7'b1000000;
`else
   localparam int unsigned STALL_WANT = 50;
   localparam logic [6:0]  LOAD_OUT   = 7'b1001100;
`endif

   logic        clk = 1'b0;
   logic        i_reset, i_start, i_valid;
   logic [31:0] i_data;
   logic        o_ready, o_sck, o_mosi, o_hSync, o_vSync, o_busy, o_frameDone, o_stall;

   int unsigned applied = 0, miscompares = 0;
   logic [31:0] exp_q[$];
   bit          src_en = 1'b0, rand_valid = 1'b0, stall_win = 1'b0;
   int unsigned pause_at = 0;
   int unsigned stall_cycles = 0, hs_count = 0, vs_count = 0, done_count = 0;

   spi_line_sender #(
      .CLOCK_SPEED(50), .SCK_DIV(SCK_DIV), .WORDS_PER_LINE(WPL),
      .LINES_PER_FRAME(LPF), .LINE_GAP(LINE_GAP)
   ) dut (
      .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_data(i_data),
      .i_valid(i_valid), .o_ready(o_ready), .o_sck(o_sck), .o_mosi(o_mosi),
      .o_hSync(o_hSync), .o_vSync(o_vSync), .o_busy(o_busy),
      .o_frameDone(o_frameDone), .o_stall(o_stall)
   );

   initial forever #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      applied++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, got, want, $time);
      end
   endtask

   // Word source: every accepted word goes on the scoreboard queue.
   initial begin : source
      bit          acc;
      int unsigned acc_cnt, pause_rem;
      acc_cnt = 0; pause_rem = 0;
      i_data = 32'h0000_0001; i_valid = 1'b0;
      forever begin
         @(negedge clk);
         acc = i_valid && o_ready;
         @(posedge clk); #1;
         if (acc) begin
            exp_q.push_back(i_data);
            acc_cnt++;
            i_data = $urandom();
            if (acc_cnt == pause_at) pause_rem = PAUSE;
         end
         if (pause_rem > 0) begin
            i_valid = 1'b0;
            pause_rem--;
         end else begin
            i_valid = src_en && (!rand_valid || ($urandom_range(0, 3) != 0));
         end
      end
   end

   // Receiver model: samples mosi at each sck rise, LSB first; realigns on vSync.
   initial begin : receiver
      logic        sck_q, mosi_q, vs_q, hs_q, done_q;
      logic [31:0] rx_sh;
      int unsigned vs_len, hs_len, rx_bits, line_rises, word_in_line, line_idx;
      sck_q = 0; mosi_q = 0; vs_q = 0; hs_q = 0; done_q = 0; rx_sh = '0;
      vs_len = 0; hs_len = 0; rx_bits = 0; line_rises = 0; word_in_line = 0; line_idx = 0;
      forever begin
         @(negedge clk);
         if (i_reset) begin
            rx_bits = 0; line_rises = 0; word_in_line = 0; line_idx = 0;
            vs_len = 0; hs_len = 0;
         end else begin
            check("link_rules",
                  32'(!(o_sck && (o_stall || o_vSync || o_hSync)) &&
                      !(o_sck && sck_q && (o_mosi != mosi_q))), 32'd1);
            if (o_sck && !sck_q) begin
               rx_sh = {o_mosi, rx_sh[31:1]};
               rx_bits++;
               line_rises++;
               if (rx_bits == 32) begin
                  rx_bits = 0;
`ifdef PATTERN_GEN_EN
                  check("pattern_word", rx_sh, {16'(line_idx), 8'h00, 8'(word_in_line)});
`else
                  check("word_available", 32'(exp_q.size() != 0), 32'd1);
                  if (exp_q.size() != 0) check("word_data", rx_sh, exp_q.pop_front());
`endif
                  word_in_line++;
               end
            end
            if (o_vSync) begin
               vs_len++;
               rx_bits = 0; line_rises = 0; word_in_line = 0; line_idx = 0;
            end else if (vs_q) begin
               check("vsync_len", vs_len, 2 * SCK_DIV);
               vs_len = 0;
               vs_count++;
            end
            if (o_hSync && !hs_q) begin
               check("line_sck_rises", line_rises, 32 * WPL);
               check("line_words", word_in_line, WPL);
               hs_count++;
               line_rises = 0; word_in_line = 0; line_idx++;
            end
            if (o_hSync) hs_len++;
            else if (hs_q) begin
               check("hsync_len", hs_len, 2 * SCK_DIV);
               hs_len = 0;
            end
            if (o_frameDone) begin
               done_count++;
               check("done_busy_low", 32'(o_busy), 32'd0);
               check("done_one_cycle", 32'(done_q), 32'd0);
            end
            if (stall_win && o_stall) stall_cycles++;
         end
         sck_q = o_sck; mosi_q = o_mosi; vs_q = o_vSync; hs_q = o_hSync; done_q = o_frameDone;
      end
   end

   task automatic pulse_start();
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget, input bit poke_start, output bit ok);
      ok = 1'b0;
      for (int unsigned n = 0; n < budget && !ok; n++) begin
         @(negedge clk);
         if (o_frameDone) begin
            ok = 1'b1;
            if (poke_start) i_start = 1'b1;
         end
      end
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   typedef struct {
      logic       rst;
      logic       start;
      logic [6:0] want;   // {busy, vSync, hSync, ready, stall, sck, frameDone}
   } vec_t;

   initial begin : main
      vec_t        vecs[13];
      bit          ok;
      int unsigned hs0, d0, vs0, sck_hi, busy_hi;

      vecs[0] = '{1'b1, 1'b0, 7'b0000000};
      vecs[1] = '{1'b0, 1'b0, 7'b0000000};
      vecs[2] = '{1'b0, 1'b1, 7'b1100000};
      for (int unsigned i = 3; i <= 9; i++) vecs[i] = '{1'b0, 1'b0, 7'b1100000};
      vecs[10] = '{1'b0, 1'b0, LOAD_OUT};
      vecs[11] = '{1'b0, 1'b1, LOAD_OUT};
      vecs[12] = '{1'b0, 1'b0, LOAD_OUT};

      i_reset = 1'b1; i_start = 1'b0;
      for (int unsigned i = 0; i < 13; i++) begin
         i_reset = vecs[i].rst;
         i_start = vecs[i].start;
         @(posedge clk); #1;
         check($sformatf("step%0d_outputs", i),
               32'({o_busy, o_vSync, o_hSync, o_ready, o_stall, o_sck, o_frameDone}),
               32'(vecs[i].want));
      end
      i_start = 1'b0;

      // Frame 1: first word 0x1, steady source with a long gap after word 3.
      hs0 = hs_count; d0 = done_count;
      pause_at = 4; src_en = 1'b1;
      ok = 1'b0;
      for (int unsigned n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         ok = !o_ready;
      end
      check("f1_left_load", 32'(ok), 32'd1);
      stall_win = 1'b1;
      wait_done(20000, 1'b0, ok);
      stall_win = 1'b0;
      check("f1_done_seen", 32'(ok), 32'd1);
      check("f1_hsyncs", hs_count - hs0, LPF);
      check("f1_done_pulses", done_count - d0, 1);
      check("f1_stall_cycles", stall_cycles, STALL_WANT);
      check("f1_queue_drained", exp_q.size(), 0);
      check("f1_busy_after", 32'(o_busy), 32'd0);

      // Frame 2: random valid, start mid-frame and in the DONE cycle are both ignored.
      pause_at = 0; rand_valid = 1'b1;
      hs0 = hs_count; d0 = done_count; vs0 = vs_count;
      pulse_start();
      check("f2_busy_after_start", 32'(o_busy), 32'd1);
      repeat (3000) @(posedge clk);
      #1;
      pulse_start();
      wait_done(20000, 1'b1, ok);
      check("f2_done_seen", 32'(ok), 32'd1);
      repeat (50) @(posedge clk);
      #1;
      check("f2_hsyncs", hs_count - hs0, LPF);
      check("f2_done_pulses", done_count - d0, 1);
      check("f2_single_vsync", vs_count - vs0, 1);
      check("f2_queue_drained", exp_q.size(), 0);
      check("f2_idle_after", 32'(o_busy), 32'd0);

      // Reset while shifting: outputs drop before the next clock edge.
      rand_valid = 1'b0;
      pulse_start();
      ok = 1'b0;
      for (int unsigned n = 0; n < 2000 && !ok; n++) begin
         @(negedge clk);
         ok = o_sck;
      end
      check("rst_reached_shift", 32'(ok), 32'd1);
      src_en = 1'b0;
      #2 i_reset = 1'b1;
      #1;
      check("rst_async_outputs",
            32'({o_busy, o_vSync, o_hSync, o_ready, o_stall, o_sck, o_frameDone, o_mosi}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      exp_q.delete();
      i_reset = 1'b0;
      sck_hi = 0; busy_hi = 0;
      repeat (100) begin
         @(negedge clk);
         if (o_sck) sck_hi++;
         if (o_busy) busy_hi++;
      end
      check("rst_no_sck_after", sck_hi, 0);
      check("rst_stays_idle", busy_hi, 0);

      // Frame 3: recovery after reset with random data and valid.
      @(posedge clk); #1;
      src_en = 1'b1; rand_valid = 1'b1;
      hs0 = hs_count; d0 = done_count;
      pulse_start();
      wait_done(20000, 1'b0, ok);
      check("f3_done_seen", 32'(ok), 32'd1);
      check("f3_hsyncs", hs_count - hs0, LPF);
      check("f3_done_pulses", done_count - d0, 1);
      check("f3_queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
